// File: rtl/cplx_alu_arbiter_if.sv
// Requester, response and ALU-side signals of the complex-ALU arbiter.
// slave = arbiter side, master = requesters / ALU side.
interface cplx_alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_op;
    logic [31:0] req0_opnd;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_op;
    logic [31:0] req1_opnd;

    logic [7:0]  alu_A1;
    logic [7:0]  alu_A2;
    logic [7:0]  alu_B1;
    logic [7:0]  alu_B2;
    logic [7:0]  alu_Op;
    logic [7:0]  alu_Out1;
    logic [7:0]  alu_Out2;
    logic        alu_CompReg;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [7:0]  rsp0_out1;
    logic [7:0]  rsp0_out2;
    logic        rsp0_comp;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [7:0]  rsp1_out1;
    logic [7:0]  rsp1_out2;
    logic        rsp1_comp;
    logic        rsp1_err;

    modport slave (
        input  req0_valid, req0_op, req0_opnd, req1_valid, req1_op, req1_opnd,
        output req0_ready, req1_ready,
        output alu_A1, alu_A2, alu_B1, alu_B2, alu_Op,
        input  alu_Out1, alu_Out2, alu_CompReg,
        output rsp0_valid, rsp0_out1, rsp0_out2, rsp0_comp, rsp0_err,
        output rsp1_valid, rsp1_out1, rsp1_out2, rsp1_comp, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_opnd, req1_valid, req1_op, req1_opnd,
        input  req0_ready, req1_ready,
        input  alu_A1, alu_A2, alu_B1, alu_B2, alu_Op,
        output alu_Out1, alu_Out2, alu_CompReg,
        input  rsp0_valid, rsp0_out1, rsp0_out2, rsp0_comp, rsp0_err,
        input  rsp1_valid, rsp1_out1, rsp1_out2, rsp1_comp, rsp1_err,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/cplx_alu_arbiter.sv
// Round-robin sharing of one clocked complex ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the grant/reject statistics counters.
module cplx_alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    cplx_alu_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1,
    output logic [15:0]        reject_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

    localparam logic [2:0] CNT_LAST = 3'(ALU_LAT);

    state_t      state_reg;
    logic        last_grant_reg;
    logic        cur_reg;
    logic [2:0]  cnt_reg;
    logic [7:0]  a1_reg, a2_reg, b1_reg, b2_reg;
    logic [3:0]  op_reg;

    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  req_op [2];
    logic [31:0] req_opnd [2];
    logic [1:0]  elig;
    logic        grant_next;
    logic        accept;
    logic        legal;
    logic [1:0]  grant_sel;
    logic [1:0]  cur_sel;
    logic [3:0]  sel_op;
    logic [31:0] sel_opnd;
    logic        cmp_op;
    logic        unused_op_bits;

    function automatic logic is_legal(input logic [3:0] code);
        return !(code inside {4'd3, 4'd7, 4'd8, 4'd15});
    endfunction

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_op[0]   = bus.req0_op[3:0];
    assign req_op[1]   = bus.req1_op[3:0];
    assign req_opnd[0] = bus.req0_opnd;
    assign req_opnd[1] = bus.req1_opnd;
    assign unused_op_bits = ^{bus.req0_op[7:4], bus.req1_op[7:4]};

    // Tie-break toward the requester that did not win last time.
    assign grant_next = (elig == 2'b11) ? ~last_grant_reg : elig[1];
    assign accept     = (state_reg == IDLE) && (|elig);
    assign grant_sel  = {grant_next, ~grant_next};
    assign cur_sel    = {cur_reg, ~cur_reg};
    assign sel_op     = req_op[grant_next];
    assign sel_opnd   = req_opnd[grant_next];
    assign legal      = is_legal(sel_op);
    assign cmp_op     = (op_reg >= 4'd9) && (op_reg <= 4'd14);

    assign bus.req0_ready = accept && grant_sel[0];
    assign bus.req1_ready = accept && grant_sel[1];

    assign bus.alu_A1 = a1_reg;
    assign bus.alu_A2 = a2_reg;
    assign bus.alu_B1 = b1_reg;
    assign bus.alu_B2 = b2_reg;
    assign bus.alu_Op = {4'b0000, op_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            cur_reg        <= 1'b0;
            cnt_reg        <= 3'd0;
            a1_reg         <= 8'd0;
            a2_reg         <= 8'd0;
            b1_reg         <= 8'd0;
            b2_reg         <= 8'd0;
            op_reg         <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_grant_reg <= grant_next;
                        cur_reg        <= grant_next;
                        // Rejected codes never touch the ALU inputs.
                        if (legal) begin
                            {a1_reg, a2_reg, b1_reg, b2_reg} <= sel_opnd;
                            op_reg    <= sel_op;
                            cnt_reg   <= 3'd0;
                            state_reg <= DRIVE;
                        end else begin
                            state_reg <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                CAPTURE: state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic       valid_reg;
        logic [7:0] out1_reg;
        logic [7:0] out2_reg;
        logic       comp_reg;
        logic       err_reg;

        assign elig[gi] = req_valid[gi] & ~valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                out1_reg  <= 8'd0;
                out2_reg  <= 8'd0;
                comp_reg  <= 1'b0;
                err_reg   <= 1'b0;
            end else begin
                if (valid_reg && rsp_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
                if (accept && grant_sel[gi] && !legal) begin
                    out1_reg <= 8'd0;
                    out2_reg <= 8'd0;
                    comp_reg <= 1'b0;
                    err_reg  <= 1'b1;
                end
                if ((state_reg == CAPTURE) && cur_sel[gi]) begin
                    out1_reg <= bus.alu_Out1;
                    out2_reg <= bus.alu_Out2;
                    comp_reg <= cmp_op & bus.alu_CompReg;
                    err_reg  <= 1'b0;
                end
                if ((state_reg == RESP) && cur_sel[gi]) begin
                    valid_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp0_valid = g_rsp[0].valid_reg;
    assign bus.rsp0_out1  = g_rsp[0].out1_reg;
    assign bus.rsp0_out2  = g_rsp[0].out2_reg;
    assign bus.rsp0_comp  = g_rsp[0].comp_reg;
    assign bus.rsp0_err   = g_rsp[0].err_reg;
    assign bus.rsp1_valid = g_rsp[1].valid_reg;
    assign bus.rsp1_out1  = g_rsp[1].out1_reg;
    assign bus.rsp1_out2  = g_rsp[1].out2_reg;
    assign bus.rsp1_comp  = g_rsp[1].comp_reg;
    assign bus.rsp1_err   = g_rsp[1].err_reg;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
            reject_cnt <= 16'd0;
        end else if (accept) begin
            if (grant_sel[0] && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant_sel[1] && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
            if (!legal && (reject_cnt != 16'hFFFF))       reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cplx_alu_arbiter.sv
// Randomized bench for cplx_alu_arbiter: a latency-accurate ALU stub plus a
// transaction-level reference model of grants, responses and ALU drive.
module tb_cplx_alu_arbiter;
    localparam int ALU_LAT = 1;

    logic clk;
    logic rst;
    cplx_alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, reject_cnt;
`endif

    cplx_alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .reject_cnt (reject_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {comp, out1, out2}; non-compare ops put a1[0] on the flag as noise.
    function automatic logic [16:0] cplx_math(input logic [3:0] op, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] b1,
                                              input logic [7:0] b2);
        int sa1, sa2, sb1, sb2, r1, r2;
        logic c;
        sa1 = int'($signed(a1)); sa2 = int'($signed(a2));
        sb1 = int'($signed(b1)); sb2 = int'($signed(b2));
        r1 = 0; r2 = 0; c = a1[0];
        case (op)
            4'd0: begin r1 = sa1 + sb1; r2 = sa2 + sb2; end
            4'd1: begin r1 = sa1 - sb1; r2 = sa2 - sb2; end
            4'd2: begin r1 = sa1 * sb1 - sa2 * sb2; r2 = sa1 * sb2 + sa2 * sb1; end
            4'd4: begin r1 = sa1 * sb1; r2 = sa2 * sb2; end
            4'd5: begin r1 = -sa1; r2 = -sa2; end
            4'd6: begin r1 = sa1; r2 = -sa2; end
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
                r1 = sa1 - sb1; r2 = sa2 - sb2;
                case (op)
                    4'd9:    c = (sa1 < sb1);
                    4'd10:   c = (a1 == b1) && (a2 == b2);
                    4'd11:   c = (sa1 > sb1);
                    4'd12:   c = !((a1 == b1) && (a2 == b2));
                    4'd13:   c = (sa1 <= sb1);
                    default: c = (sa1 >= sb1);
                endcase
            end
            default: begin r1 = 0; r2 = 0; end
        endcase
        return {c, r1[7:0], r2[7:0]};
    endfunction

    // ALU stub: result appears ALU_LAT edges after its inputs.
    logic [16:0] pipe [ALU_LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= cplx_math(bus.alu_Op[3:0], bus.alu_A1, bus.alu_A2, bus.alu_B1, bus.alu_B2);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.alu_CompReg = pipe[ALU_LAT-1][16];
    assign bus.alu_Out1    = pipe[ALU_LAT-1][15:8];
    assign bus.alu_Out2    = pipe[ALU_LAT-1][7:0];

    typedef struct {
        bit         act;
        int         vis;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       c;
        logic       e;
    } pend_t;

    int          n_chk, n_fail, k, free_at;
    pend_t       pend [2];
    bit          last;
    logic [7:0]  m_a1, m_a2, m_b1, m_b2, m_op;
    int          m_gcnt [2];
    int          m_rej;
    bit          v [2];
    bit          rr [2];
    logic [7:0]  opv [2];
    logic [31:0] opndv [2];
    bit          rst_d;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic pend_t ref_rsp(input logic [7:0] op, input logic [31:0] opnd);
        pend_t p;
        logic [3:0] code;
        logic [16:0] m;
        code = op[3:0];
        p.act = 1'b1; p.vis = 0;
        if (code inside {4'd3, 4'd7, 4'd8, 4'd15}) begin
            p.o1 = 8'd0; p.o2 = 8'd0; p.c = 1'b0; p.e = 1'b1;
        end else begin
            m = cplx_math(code, opnd[31:24], opnd[23:16], opnd[15:8], opnd[7:0]);
            p.o1 = m[15:8]; p.o2 = m[7:0];
            p.c = (code >= 4'd9 && code <= 4'd14) ? m[16] : 1'b0;
            p.e = 1'b0;
        end
        return p;
    endfunction

    task automatic model_reset();
        pend[0].act = 0; pend[1].act = 0;
        free_at = k + 1; last = 1'b1;
        m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0; m_op = 0;
        m_gcnt[0] = 0; m_gcnt[1] = 0; m_rej = 0;
    endtask

    task automatic model_cycle();
        bit mv [2];
        bit elig [2];
        bit gv, any, grant;
        logic [7:0] d_o1 [2];
        logic [7:0] d_o2 [2];
        logic d_c [2];
        logic d_e [2];
        logic d_v [2];
        logic d_r [2];
        int lat;
        pend_t p;
        d_v[0] = bus.rsp0_valid; d_o1[0] = bus.rsp0_out1; d_o2[0] = bus.rsp0_out2;
        d_c[0] = bus.rsp0_comp;  d_e[0] = bus.rsp0_err;   d_r[0] = bus.req0_ready;
        d_v[1] = bus.rsp1_valid; d_o1[1] = bus.rsp1_out1; d_o2[1] = bus.rsp1_out2;
        d_c[1] = bus.rsp1_comp;  d_e[1] = bus.rsp1_err;   d_r[1] = bus.req1_ready;
        for (int n = 0; n < 2; n++) begin
            mv[n] = pend[n].act && (k >= pend[n].vis);
            check_val($sformatf("rsp%0d_valid", n), 32'(d_v[n]), 32'(mv[n]));
            if (mv[n]) begin
                check_val($sformatf("rsp%0d_out1", n), 32'(d_o1[n]), 32'(pend[n].o1));
                check_val($sformatf("rsp%0d_out2", n), 32'(d_o2[n]), 32'(pend[n].o2));
                check_val($sformatf("rsp%0d_comp", n), 32'(d_c[n]), 32'(pend[n].c));
                check_val($sformatf("rsp%0d_err", n), 32'(d_e[n]), 32'(pend[n].e));
            end
        end
        check_val("alu_operands", {bus.alu_A1, bus.alu_A2, bus.alu_B1, bus.alu_B2},
                  {m_a1, m_a2, m_b1, m_b2});
        check_val("alu_op", 32'(bus.alu_Op), 32'(m_op));
`ifdef ALU_ARB_STATS_EN
        check_val("grant_cnt0", 32'(grant_cnt0), 32'(m_gcnt[0]));
        check_val("grant_cnt1", 32'(grant_cnt1), 32'(m_gcnt[1]));
        check_val("reject_cnt", 32'(reject_cnt), 32'(m_rej));
`endif
        for (int n = 0; n < 2; n++) elig[n] = v[n] && !mv[n];
        any   = elig[0] || elig[1];
        gv    = (elig[0] && elig[1]) ? !last : elig[1];
        grant = (k >= free_at) && any;
        check_val("req0_ready", 32'(d_r[0]), 32'(grant && !gv));
        check_val("req1_ready", 32'(d_r[1]), 32'(grant && gv));
        if (grant) begin
            p = ref_rsp(opv[gv], opndv[gv]);
            lat = p.e ? 1 : ALU_LAT + 3;
            p.vis = k + 1 + lat;
            pend[gv] = p;
            free_at = p.vis;
            last = gv;
            if (!p.e) begin
                {m_a1, m_a2, m_b1, m_b2} = opndv[gv];
                m_op = {4'd0, opv[gv][3:0]};
            end
            if (m_gcnt[gv] < 65535) m_gcnt[gv]++;
            if (p.e && m_rej < 65535) m_rej++;
            $display("cycle %0d: accept req%0d op=%02h opnd=%08h", k, gv, opv[gv], opndv[gv]);
            v[gv] = 0;
        end
        for (int n = 0; n < 2; n++) begin
            if (mv[n] && rr[n]) begin
                pend[n].act = 0;
                $display("cycle %0d: rsp%0d out1=%02h out2=%02h comp=%0b err=%0b", k, n,
                         d_o1[n], d_o2[n], d_c[n], d_e[n]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        rst = rst_d;
        bus.req0_valid = v[0]; bus.req0_op = opv[0]; bus.req0_opnd = opndv[0];
        bus.req1_valid = v[1]; bus.req1_op = opv[1]; bus.req1_opnd = opndv[1];
        bus.rsp0_ready = rr[0]; bus.rsp1_ready = rr[1];
        #1;
        if (rst_d) model_reset();
        else model_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int n, input logic [7:0] op, input logic [31:0] opnd);
        v[n] = 1; opv[n] = op; opndv[n] = opnd;
    endtask

    task automatic pulse_ready(input int n);
        rr[n] = 1; run(1); rr[n] = 0; run(1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; k = 0;
        v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
        opv[0] = 0; opv[1] = 0; opndv[0] = 0; opndv[1] = 0;
        rst = 1'b1; rst_d = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        bus.req0_op = 0; bus.req1_op = 0; bus.req0_opnd = 0; bus.req1_opnd = 0;
        model_reset();
        run(3);
        rst_d = 0;
        run(2);

        // ADD on requester 0
        set_req(0, 8'h00, 32'h05060708);
        run(6);
        check_val("add_valid", 32'(bus.rsp0_valid), 32'd1);
        check_val("add_out", {bus.rsp0_out1, bus.rsp0_out2}, 32'h0C0E);
        pulse_ready(0);

        // SUB on requester 1, response held for five cycles
        set_req(1, 8'h01, 32'h05060708);
        run(11);
        check_val("sub_out", {bus.rsp1_out1, bus.rsp1_out2}, 32'hFEFE);
        pulse_ready(1);

        // MUL fairness straight after reset
        rst_d = 1; run(1); rst_d = 0;
        set_req(0, 8'h02, 32'h01010101);
        set_req(1, 8'h02, 32'h01010101);
        run(14);
        check_val("mul0_out", {bus.rsp0_out1, bus.rsp0_out2}, 32'h0002);
        check_val("mul1_out", {bus.rsp1_out1, bus.rsp1_out2}, 32'h0002);
        rr[0] = 1; rr[1] = 1;
        run(1);
        set_req(0, 8'h02, 32'h01010101);
        set_req(1, 8'h02, 32'h01010101);
        run(14);
        rr[0] = 0; rr[1] = 0;

        // Compares
        set_req(0, 8'hA0 | 8'h0A, 32'h01010101);
        run(6);
        check_val("equal_comp", 32'(bus.rsp0_comp), 32'd1);
        pulse_ready(0);
        set_req(1, 8'h09, 32'h05060708);
        run(6);
        check_val("less_comp", 32'(bus.rsp1_comp), 32'd1);
        pulse_ready(1);
        set_req(0, 8'h06, 32'h03020000);
        run(6);
        check_val("conj_comp", 32'(bus.rsp0_comp), 32'd0);
        check_val("conj_out", {bus.rsp0_out1, bus.rsp0_out2}, 32'h03FE);
        pulse_ready(0);

        // Reject
        set_req(0, 8'h0F, 32'h00FF000A);
        run(3);
        check_val("rej_err", {31'd0, bus.rsp0_err}, 32'd1);
        check_val("rej_out", {bus.rsp0_out1, bus.rsp0_out2}, 32'h0000);
`ifdef ALU_ARB_STATS_EN
        check_val("rej_cnt", 32'(reject_cnt), 32'd1);
`endif
        pulse_ready(0);

        // Reset while the ALU is being driven
        set_req(0, 8'h00, 32'h11223344);
        run(3);
        rst_d = 1; run(1); rst_d = 0;
        run(1);
        check_val("abort_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        set_req(0, 8'h00, 32'h01020304);
        set_req(1, 8'h01, 32'h01020304);
        rr[0] = 1; rr[1] = 1;
        run(14);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && $urandom_range(0, 2) == 0)
                    set_req(n, 8'($urandom_range(0, 255)), $urandom);
                rr[n] = ($urandom_range(0, 2) != 0);
            end
            rst_d = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_d = 0; v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cplx_alu_arbiter.md
Name: cplx_alu_arbiter

Overview:
- Shares the single clocked complex-number ALU between two requesters (instruction issue and the loop/branch sequencer).
- Each requester presents an op plus a complex operand pair. The block arbitrates round-robin, drives the ALU inputs and holds them for the ALU latency, captures Out1/Out2/CompReg, and returns the result to the winning requester.
- Divide and memory-access codes are not ALU work. They are rejected with an error response.

Parameters:
- ALU_LAT, 1, number of clk edges the ALU needs between stable inputs and valid outputs (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an op pending.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  8  op code; bits [3:0] are significant, bits [7:4] are ignored.
- req0_opnd  in  32  {A1,A2,B1,B2}, i.e. A = A1 + A2·i and B = B1 + B2·i.
- req1_valid, req1_ready, req1_op, req1_opnd: same as requester 0.
- alu_A1, alu_A2, alu_B1, alu_B2  out  8 each  ALU operands.
- alu_Op  out  8  ALU op, zero-extended from 4 bits.
- alu_Out1, alu_Out2  in  8 each  ALU real/imag result.
- alu_CompReg  in  1  ALU compare flag.
- rsp0_valid  out  1  response for requester 0 is held.
- rsp0_ready  in  1  requester 0 consumes the response.
- rsp0_out1, rsp0_out2  out  8 each  result.
- rsp0_comp  out  1  compare result.
- rsp0_err  out  1  op was rejected.
- rsp1_*: same as the rsp0 group.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM returns to IDLE.
  - All rsp*_valid, rsp*_err, rsp*_comp and rsp*_out* go to 0.
  - alu_* outputs go to 0 (ADD op).
  - last_grant goes to 1, so requester 0 wins first.
  - rst during any state aborts the in-flight op. No response is produced for it.
- FSM states: IDLE, DRIVE, CAPTURE, RESP.
- IDLE:
  - Eligible requester: reqN_valid=1 and rspN_valid=0.
  - grant = the eligible requester; if both are eligible, grant the one that is not last_grant.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational and high for one cycle.
  - On acceptance, latch op and operands and set last_grant=N.
- Legal codes: 0000, 0001, 0010, 0100, 0101, 0110, 1001..1110.
  - Legal code: go to DRIVE.
  - Illegal code (0011 DIV, 0111, 1000, 1111 MEM_ACCESS): go directly to RESP with err=1, out1=out2=0, comp=0. The ALU is not driven.
- DRIVE:
  - alu_* hold the latched values for ALU_LAT+1 cycles, counted by a 3-bit counter.
  - Then go to CAPTURE.
- CAPTURE:
  - alu_* are still held.
  - Sample alu_Out1/alu_Out2/alu_CompReg into rspN registers.
  - comp = alu_CompReg for compare codes 1001..1110, otherwise 0.
  - Go to RESP.
- RESP:
  - Assert rspN_valid, then return to IDLE the next cycle.
  - rspN_valid stays high, with data stable, until the cycle rspN_ready=1 is sampled. It clears at that edge.
- Latency, from the acceptance edge to rspN_valid high:
  - Legal op: ALU_LAT+3 cycles.
  - Rejected op: 1 cycle.
- Pending responses:
  - While rspN_valid=1, requester N is not eligible.
  - The other requester may be granted, so both responses can be pending at once.
- Simultaneous events:
  - rspN_ready, and a new reqN_valid in the same cycle: the response clears at that edge. The new request becomes eligible the next cycle.
- Arithmetic and widths:
  - Results pass through unmodified as 8-bit two's-complement, wrapping modulo 256.
- Between ops, alu_* keep their last driven values. There is no toggling while idle.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, the block adds these outputs:
  - grant_cnt0 out 16: count of accepted ops from requester 0.
  - grant_cnt1 out 16: count of accepted ops from requester 1.
  - reject_cnt out 16: count of illegal-code ops.
- Counter rules:
  - Each counter saturates at 16'hFFFF.
  - Each counter is cleared by rst.
  - Each counter increments on the acceptance edge.
- When undefined, these ports and their logic do not exist. Behaviour is otherwise identical.

Test Plan:
- ADD: req0 op=00, opnd {5,6,7,8}, ALU_LAT=1 -> rsp0_valid 4 cycles after acceptance, out1=12, out2=14, comp=0, err=0.
- SUB: req1 op=01, opnd {5,6,7,8} -> out1=8'hFE, out2=8'hFE. Hold rsp1_ready=0 for 5 cycles -> rsp1_valid and data remain stable; the clear follows rsp1_ready.
- MUL and fairness: after reset, both valid on the same cycle, both MUL with opnd {1,1,1,1} -> req0 is granted first. Then req1 -> each gets out1=0, out2=2. A third back-to-back round grants req0 and req1 alternately.
- Compares: EQUAL_COMP (1010) with opnd {1,1,1,1} -> comp=1. LESS_COMP (1001) with opnd {5,6,7,8}, result taken from the ALU -> comp equals alu_CompReg. CONJ (0110) -> comp=0 regardless of alu_CompReg.
- Reject: req0 op=8'h0F, opnd {0,255,0,10} -> rsp0_valid 1 cycle after acceptance, err=1, out1=out2=0. alu_* unchanged. With ALU_ARB_STATS_EN, reject_cnt=1.
- Reset mid-op: assert rst for 1 cycle during DRIVE -> next cycle state is IDLE, all rsp*_valid=0, alu_*=0, no response for the aborted op. The next simultaneous request grants req0.
